// File: rtl/cla_accum_sequencer.sv
// Sequencer that streams 32-bit words through an external combinational
// carry-lookahead adder and returns the running total with sticky carry-out.
module cla_accum_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_len,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_add_a,
    output logic [DATA_W-1:0] o_add_b,
    input  logic [DATA_W-1:0] i_add_sum,
    output logic [DATA_W-1:0] o_result,
    output logic              o_overflow,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  len, len_nxt;
    logic              ovf, ovf_nxt;
    logic              cy;
    logic              last;

    // Carry-out recovered from operand and sum MSBs; the adder has no carry port.
    assign cy = (o_add_a[DATA_W-1] & o_add_b[DATA_W-1])
              | ((o_add_a[DATA_W-1] ^ o_add_b[DATA_W-1]) & ~i_add_sum[DATA_W-1]);

    assign last = (cnt == len - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len   <= len_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        len_nxt        = len;
        ovf_nxt        = ovf;
        o_data_ready   = 1'b0;
        o_add_a        = acc;
        o_add_b        = '0;
        o_result_valid = 1'b0;
        o_result       = '0;
        o_overflow     = 1'b0;
        o_busy         = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (i_start) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                    if (i_len != '0) begin
                        len_nxt   = i_len;
                        cnt_nxt   = '0;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                o_data_ready = 1'b1;
                o_add_b      = i_data;
                if (i_data_valid) begin
                    acc_nxt = i_add_sum;
                    cnt_nxt = cnt + CNT_W'(1);
                    ovf_nxt = ovf | cy;
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                o_result_valid = 1'b1;
                o_result       = acc;
                o_overflow     = ovf;
                if (i_result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort takes priority over any beat or result handshake this cycle.
        if (i_clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_accum_sequencer.sv
// Bench for cla_accum_sequencer: directed scenarios with literal expectations,
// then random traffic checked every cycle against a job-level sum model.
module tb_cla_accum_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] add_sum;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              result_valid;
    logic              result_ready = 1'b1;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    // Stand-in for the combinational carry-lookahead adder.
    assign add_sum = add_a + add_b;

    cla_accum_sequencer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_len         (len),
        .i_clear       (clear),
        .i_data        (data),
        .i_data_valid  (data_valid),
        .o_data_ready  (data_ready),
        .o_add_a       (add_a),
        .o_add_b       (add_b),
        .i_add_sum     (add_sum),
        .o_result      (result),
        .o_overflow    (overflow),
        .o_result_valid(result_valid),
        .i_result_ready(result_ready),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Job-level model: 0 idle, 1 taking operands, 2 reporting.
    int              m_phase = 0;
    int              m_left  = 0;
    longint unsigned m_total = 0;

    always @(posedge clk) begin
        if (rst || clear) begin
            m_phase = 0;
            m_total = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_total = 0;
                    m_left  = int'(len);
                    m_phase = (len != 0) ? 1 : 2;
                end
                1: if (data_valid) begin
                    m_total = m_total + longint'(data);
                    m_left  = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (result_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [31:0] lo;
            bit          rep;
            lo  = m_total[31:0];
            rep = (m_phase == 2);
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("data_ready", 64'(data_ready), 64'(m_phase == 1));
            chk("add_a", 64'(add_a), 64'(lo));
            chk("add_b", 64'(add_b), (m_phase == 1) ? 64'(data) : 64'd0);
            chk("result_valid", 64'(result_valid), 64'(rep));
            chk("result", 64'(result), rep ? 64'(lo) : 64'd0);
            chk("overflow", 64'(overflow),
                64'(rep && (m_total >= 64'h1_0000_0000)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        data       = d;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int k;
        for (k = 0; k < 50 && !result_valid; k++) cyc();
        if (!result_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        cyc();
        cyc();
        rst      = 1'b0;
        check_en = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", 64'(result), 64'd0);

        // 1+2+3 back to back; result must be up right after the third beat
        start_job(3);
        beat(32'd1);
        beat(32'd2);
        beat(32'd3);
        chk("t1_valid", 64'(result_valid), 64'd1);
        chk("t1_result", 64'(result), 64'd6);
        chk("t1_ovf", 64'(overflow), 64'd0);
        cyc();
        chk("t1_idle", 64'(busy), 64'd0);

        // wrap with carry-out
        start_job(2);
        beat(32'hFFFF_FFFF);
        beat(32'h0000_0002);
        wait_result("t2");
        chk("t2_result", 64'(result), 64'h1);
        chk("t2_ovf", 64'(overflow), 64'd1);
        cyc();

        // gaps in valid, consumer stalls for 5 cycles
        result_ready = 1'b0;
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            cyc();
            beat(32'h10);
        end
        wait_result("t3");
        for (int i = 0; i < 5; i++) begin
            chk("t3_result", 64'(result), 64'h40);
            chk("t3_ready", 64'(data_ready), 64'd0);
            cyc();
        end
        result_ready = 1'b1;
        cyc();
        chk("t3_idle", 64'(busy), 64'd0);

        // empty job
        start_job(0);
        chk("t4_valid", 64'(result_valid), 64'd1);
        chk("t4_result", 64'(result), 64'd0);
        chk("t4_ovf", 64'(overflow), 64'd0);
        cyc();
        chk("t4_idle", 64'(busy), 64'd0);

        // abort after 2 beats; stray start while busy
        start_job(5);
        beat(32'd100);
        beat(32'd200);
        start_job(9);
        chk("t5_still_accum", 64'(data_ready), 64'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5_cleared", 64'(busy), 64'd0);
        start_job(1);
        beat(32'd7);
        wait_result("t5");
        chk("t5_result", 64'(result), 64'd7);
        chk("t5_ovf", 64'(overflow), 64'd0);
        cyc();

        // reset mid-job
        start_job(4);
        beat(32'hDEAD_BEEF);
        data       = 32'h1234_5678;
        data_valid = 1'b1;
        rst        = 1'b1;
        cyc();
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(data_ready), 64'd0);
        chk("t6_add_a", 64'(add_a), 64'd0);
        chk("t6_add_b", 64'(add_b), 64'd0);
        chk("t6_valid", 64'(result_valid), 64'd0);
        chk("t6_result", 64'(result), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        rst        = 1'b0;
        data_valid = 1'b0;
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            clear        = ($urandom_range(0, 59) == 0);
            start        = ($urandom_range(0, 3) == 0);
            len          = ($urandom_range(0, 15) == 0) ?
                           CNT_W'($urandom_range(0, 40)) :
                           CNT_W'($urandom_range(0, 6));
            data_valid   = ($urandom_range(0, 2) != 0);
            data         = ($urandom_range(0, 3) == 0) ?
                           (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) :
                           32'($urandom);
            result_ready = ($urandom_range(0, 1) == 1);
            cyc();
        end
        rst   = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
